router_switch_alloc: RTL and testbench

Switch allocator for the 5-port mesh router: computes each input's output port by XY dimension-order routing against the router's own coordinates, then arbitrates every output port round-robin among requesting inputs. A grant is held from head flit to tail flit (wormhole), and flit transfers are gated by downstream readiness. It sits between the router's input buffers and its crossbar; `out_sel` drives the crossbar mux selects.

---
 rtl/router_switch_alloc.sv | 153 +++++++++++++++
 tb/tb_router_switch_alloc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_switch_alloc.sv
// router_switch_alloc
// Switch allocator for the 5-port mesh router. Each input's output port is
// chosen by XY dimension-order routing against this router's coordinates;
// every output arbitrates round-robin among its requesters and holds the
// grant from head flit to tail flit (wormhole). Transfers are gated by
// downstream readiness.
// Port index everywhere: 0=North 1=South 2=East 3=West 4=Local.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid[5], in_tail[5]  head-of-buffer flit present / is a tail
//   in_dest_x, in_dest_y     5*CW destination coords, used while unlocked
//   out_ready[5]             downstream of each output can accept
//   in_grant[5]              input's flit transfers this cycle
//   out_fire[5]              a flit leaves the output this cycle
//   out_lock[5]              output allocated to a packet
//   out_sel[15]              3-bit owner per output, 3'd7 when unlocked
//   route_err[5]             sticky U-turn request flag per input
module router_switch_alloc #(
   parameter int unsigned XCOORD = 0,
   parameter int unsigned YCOORD = 0,
   parameter int unsigned CW     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      in_valid,
   input  logic [4:0]      in_tail,
   input  logic [5*CW-1:0] in_dest_x,
   input  logic [5*CW-1:0] in_dest_y,
   input  logic [4:0]      out_ready,
   output logic [4:0]      in_grant,
   output logic [4:0]      out_fire,
   output logic [4:0]      out_lock,
   output logic [14:0]     out_sel,
   output logic [4:0]      route_err
);

   localparam logic [CW-1:0] MY_X = CW'(XCOORD);
   localparam logic [CW-1:0] MY_Y = CW'(YCOORD);

   localparam logic [2:0] P_N = 3'd0;
   localparam logic [2:0] P_S = 3'd1;
   localparam logic [2:0] P_E = 3'd2;
   localparam logic [2:0] P_W = 3'd3;
   localparam logic [2:0] P_L = 3'd4;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t     state_q [5];
   state_t     state_d [5];
   logic [2:0] owner_q [5];
   logic [2:0] owner_d [5];
   logic [2:0] rr_q    [5];
   logic [2:0] rr_d    [5];
   logic [2:0] route   [5];
   logic [4:0] req     [5];   // req[o][i]: input i bids for output o
   logic [4:0] uturn;
   logic [4:0] in_locked;

   // (a + b) mod 5 for a, b in 0..4
   function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

   // XY dimension-order route, unsigned compares
   always_comb begin
      uturn = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         if (in_dest_x[i*CW +: CW] > MY_X)      route[i] = P_E;
         else if (in_dest_x[i*CW +: CW] < MY_X) route[i] = P_W;
         else if (in_dest_y[i*CW +: CW] > MY_Y) route[i] = P_N;
         else if (in_dest_y[i*CW +: CW] < MY_Y) route[i] = P_S;
         else                                   route[i] = P_L;
         uturn[i] = (i != 4) && (route[i] == 3'(i));
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned o = 0; o < 5; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '1;
            rr_q[o]    <= '0;
         end
         route_err <= '0;
      end else begin
         for (int unsigned o = 0; o < 5; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            rr_q[o]    <= rr_d[o];
         end
         route_err <= route_err | (in_valid & ~in_locked & uturn);
      end
   end

   // Next-state: round-robin arbitration in IDLE, release on tail fire
   always_comb begin : next_state
      logic [2:0] cand;
      cand = '0;
      for (int unsigned o = 0; o < 5; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         rr_d[o]    = rr_q[o];
         req[o]     = '0;
         for (int unsigned i = 0; i < 5; i++)
            req[o][i] = in_valid[i] && !in_locked[i] && !uturn[i] && (route[i] == 3'(o));
         case (state_q[o])
            IDLE: begin
               // Scan offsets from farthest to nearest so the last hit,
               // i.e. the first requester at or after rr_ptr, wins.
               for (int unsigned k = 0; k < 5; k++) begin
                  cand = wrap_add(rr_q[o], 3'(4 - k));
                  if (req[o][cand]) begin
                     state_d[o] = LOCKED;
                     owner_d[o] = cand;
                     rr_d[o]    = wrap_add(cand, 3'd1);
                  end
               end
            end
            LOCKED: begin
               if (out_fire[o] && in_tail[owner_q[o]]) begin
                  state_d[o] = IDLE;
                  owner_d[o] = '1;
               end
            end
            default: state_d[o] = IDLE;
         endcase
      end
   end

   // Outputs: transfers follow the registered lock, never the destination
   always_comb begin
      out_fire  = '0;
      in_grant  = '0;
      out_lock  = '0;
      out_sel   = '1;
      in_locked = '0;
      for (int unsigned o = 0; o < 5; o++) begin
         if (state_q[o] == LOCKED) begin
            out_lock[o]          = 1'b1;
            out_sel[o*3 +: 3]    = owner_q[o];
            in_locked[owner_q[o]] = 1'b1;
            if (in_valid[owner_q[o]] && out_ready[o]) begin
               out_fire[o]          = 1'b1;
               in_grant[owner_q[o]] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_router_switch_alloc.sv
// tb_router_switch_alloc
// Directed bench for router_switch_alloc at coordinates (2,2). Each input is
// fed by a simple packet source (flits remaining, destination); a per-cycle
// reference model of output ownership and round-robin pointers predicts
// in_grant, out_fire, out_lock, out_sel and route_err, and literal checks
// pin the key scenario points.
module tb_router_switch_alloc;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [4:0]      in_valid, in_tail, out_ready;
   logic [5*CW-1:0] in_dest_x, in_dest_y;
   logic [4:0]      in_grant, out_fire, out_lock, route_err;
   logic [14:0]     out_sel;

   router_switch_alloc #(.XCOORD(2), .YCOORD(2), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_tail(in_tail),
      .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .out_ready(out_ready),
      .in_grant(in_grant), .out_fire(out_fire), .out_lock(out_lock),
      .out_sel(out_sel), .route_err(route_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // packet sources
   int len [5];
   int sx  [5];
   int sy  [5];
   logic [4:0] rdy;

   // reference model: owner per output (-1 = free), rr pointer, sticky error
   int own [5];
   int rr  [5];
   bit err [5];

   // last sampled DUT outputs
   logic [4:0]  d_grant, d_fire, d_lock, d_err;
   logic [14:0] d_sel;

   function automatic int route_of(int x, int y);
      if (x > 2) return 2;
      if (x < 2) return 3;
      if (y > 2) return 0;
      if (y < 2) return 1;
      return 4;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic send(int i, int x, int y, int n);
      len[i] = n;
      sx[i]  = x;
      sy[i]  = y;
   endtask

   task automatic cycle(bit r = 1'b0);
      logic [4:0]  efire, egrant, elock, eerr;
      logic [14:0] esel;
      int  nown [5];
      bit  busy [5];
      bit  got;
      @(negedge clk);
      rst = r;
      for (int i = 0; i < 5; i++) begin
         in_valid[i] = (len[i] > 0);
         in_tail[i]  = (len[i] == 1);
         in_dest_x[i*CW +: CW] = CW'(sx[i]);
         in_dest_y[i*CW +: CW] = CW'(sy[i]);
      end
      out_ready = rdy;
      #3;
      efire = '0; egrant = '0; elock = '0; eerr = '0; esel = '1;
      for (int o = 0; o < 5; o++) begin
         busy[o] = 1'b0;
         eerr[o] = err[o];
      end
      for (int o = 0; o < 5; o++) begin
         if (own[o] >= 0) begin
            elock[o] = 1'b1;
            esel[o*3 +: 3] = 3'(own[o]);
            busy[own[o]] = 1'b1;
            if (len[own[o]] > 0 && rdy[o]) begin
               efire[o] = 1'b1;
               egrant[own[o]] = 1'b1;
            end
         end
      end
      chk("in_grant", 32'(in_grant), 32'(egrant));
      chk("out_fire", 32'(out_fire), 32'(efire));
      chk("out_lock", 32'(out_lock), 32'(elock));
      chk("out_sel", 32'(out_sel), 32'(esel));
      chk("route_err", 32'(route_err), 32'(eerr));
      d_grant = in_grant; d_fire = out_fire; d_lock = out_lock;
      d_sel = out_sel; d_err = route_err;
      if (r) begin
         for (int i = 0; i < 5; i++) begin
            own[i] = -1; rr[i] = 0; err[i] = 1'b0; len[i] = 0;
         end
      end else begin
         for (int o = 0; o < 5; o++) begin
            nown[o] = own[o];
            if (efire[o] && len[own[o]] == 1) nown[o] = -1;
         end
         for (int o = 0; o < 5; o++) begin
            if (own[o] < 0) begin
               got = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  int c;
                  c = (rr[o] + k) % 5;
                  if (!got && len[c] > 0 && !busy[c] && route_of(sx[c], sy[c]) == o
                      && !(c != 4 && c == o)) begin
                     got = 1'b1;
                     nown[o] = c;
                     rr[o] = (c + 1) % 5;
                  end
               end
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (len[i] > 0 && !busy[i] && i != 4 && route_of(sx[i], sy[i]) == i) err[i] = 1'b1;
            if (egrant[i]) len[i]--;
         end
         for (int o = 0; o < 5; o++) own[o] = nown[o];
      end
      cyc++;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = '0; in_tail = '0; in_dest_x = '0; in_dest_y = '0; out_ready = '0;
      rdy = '1;
      for (int i = 0; i < 5; i++) begin
         len[i] = 0; sx[i] = 2; sy[i] = 2; own[i] = -1; rr[i] = 0; err[i] = 1'b0;
      end
      repeat (2) @(posedge clk);

      // reset state
      cycle();
      chk("rst_lock", 32'(d_lock), 32'h0);
      chk("rst_sel", 32'(d_sel), 32'h7fff);

      // Local -> East, 3 flits
      send(4, 3, 2, 3);
      cycle();
      chk("t1_lock_t0", 32'(d_lock[2]), 32'd0);
      cycle();
      chk("t1_sel_e", 32'(d_sel[8:6]), 32'd4);
      chk("t1_grant_t1", 32'(d_grant[4]), 32'd1);
      cycle(); cycle();
      chk("t1_grant_t3", 32'(d_grant[4]), 32'd1);
      cycle();
      chk("t1_unlock", 32'(d_lock[2]), 32'd0);

      // N, S, L all to West, single flits: order N, S, L with bubbles
      send(0, 0, 2, 1); send(1, 0, 3, 1); send(4, 0, 0, 1);
      cycle();
      cycle();
      chk("t2_sel_n", 32'(d_sel[11:9]), 32'd0);
      chk("t2_fire_n", 32'(d_fire[3]), 32'd1);
      cycle();
      chk("t2_bubble1", 32'(d_lock[3]), 32'd0);
      cycle();
      chk("t2_sel_s", 32'(d_sel[11:9]), 32'd1);
      cycle();
      cycle();
      chk("t2_sel_l", 32'(d_sel[11:9]), 32'd4);
      cycle();
      // rr[West] back at 0: North beats Local
      send(0, 0, 2, 1); send(4, 0, 2, 1);
      cycle(); cycle();
      chk("t2_rr_wrap", 32'(d_sel[11:9]), 32'd0);
      repeat (4) cycle();

      // backpressure on East
      send(4, 3, 2, 6);
      cycle(); cycle(); cycle();
      send(0, 3, 2, 1);
      rdy[2] = 1'b0;
      repeat (4) begin
         cycle();
         chk("t3_stall_fire", 32'(d_fire[2]), 32'd0);
         chk("t3_stall_sel", 32'(d_sel[8:6]), 32'd4);
      end
      rdy[2] = 1'b1;
      cycle();
      chk("t3_resume", 32'(d_fire[2]), 32'd1);
      repeat (3) cycle();
      cycle();
      chk("t3_bubble", 32'(d_lock[2]), 32'd0);
      cycle();
      chk("t3_next_owner", 32'(d_sel[8:6]), 32'd0);
      repeat (2) cycle();

      // parallel traffic on all five outputs
      send(0, 2, 0, 2); send(1, 2, 3, 2); send(2, 0, 2, 2); send(3, 3, 2, 2); send(4, 2, 2, 2);
      cycle();
      chk("t4_lock_t0", 32'(d_lock), 32'h0);
      cycle();
      chk("t4_lock_all", 32'(d_lock), 32'h1f);
      chk("t4_fire_all", 32'(d_fire), 32'h1f);
      chk("t4_sel", 32'(d_sel), 32'(15'b100_010_011_000_001));
      cycle();
      chk("t4_tail_all", 32'(d_grant), 32'h1f);
      cycle();
      chk("t4_unlock", 32'(d_lock), 32'h0);

      // U-turn on East input, Local -> North alongside
      send(2, 3, 2, 3); send(4, 2, 3, 1);
      cycle();
      chk("t5_err_t0", 32'(d_err), 32'h0);
      cycle();
      chk("t5_err_t1", 32'(d_err), 32'h04);
      chk("t5_sel_n", 32'(d_sel[2:0]), 32'd4);
      repeat (3) begin
         cycle();
         chk("t5_no_grant", 32'(d_grant[2]), 32'd0);
      end
      len[2] = 0;
      cycle();
      chk("t5_err_sticky", 32'(d_err[2]), 32'd1);

      // reset mid-packet with three outputs locked
      send(0, 2, 0, 5); send(1, 2, 3, 5); send(4, 3, 2, 5);
      cycle(); cycle();
      chk("t6_locked", 32'(d_lock), 32'h07);
      cycle(1'b1);
      cycle();
      chk("t6_lock_clr", 32'(d_lock), 32'h0);
      chk("t6_sel_clr", 32'(d_sel), 32'h7fff);
      chk("t6_err_clr", 32'(d_err), 32'h0);
      send(0, 0, 2, 1); send(4, 0, 2, 1);
      cycle(); cycle();
      chk("t6_rr_reset", 32'(d_sel[11:9]), 32'd0);
      repeat (5) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
